// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks INIT, then SUB/SHIFT/MIX/ARK per round, drops MIX in the
// final round, and waits in INIT/ARK until the key schedule supplies the round key.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] round_idx,
  output logic       sel_init,
  output logic       en_sub,
  output logic       en_shift,
  output logic       en_mix,
  output logic       en_ark,
  output logic       mix_bypass,
  output logic       key_req,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SUB   = 3'd2,
    S_SHIFT = 3'd3,
    S_MIX   = 3'd4,
    S_ARK   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       last_round;

  assign last_round = (round_q == NR_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    done       = 1'b0;
    sel_init   = 1'b0;
    en_sub     = 1'b0;
    en_shift   = 1'b0;
    en_mix     = 1'b0;
    en_ark     = 1'b0;
    mix_bypass = 1'b0;
    key_req    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          round_d = 4'd0;
        end
      end
      S_INIT: begin
        sel_init = 1'b1;
        key_req  = 1'b1;
        en_ark   = key_valid;
        if (key_valid) begin
          state_d = S_SUB;
          round_d = 4'd1;
        end
      end
      S_SUB: begin
        en_sub  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        en_shift = 1'b1;
        state_d  = last_round ? S_ARK : S_MIX;
      end
      S_MIX: begin
        en_mix  = 1'b1;
        state_d = S_ARK;
      end
      S_ARK: begin
        // The final round feeds ShiftRows straight into AddRoundKey.
        key_req    = 1'b1;
        en_ark     = key_valid;
        mix_bypass = last_round;
        if (key_valid) begin
          if (last_round) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SUB;
            round_d = round_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
        round_d = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign round_idx = round_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: NR=10 and NR=14 instances share stimulus and are
// compared every cycle against a time-indexed expectation of the control outputs.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic key_valid = 1'b1;

  logic       busy_a, done_a, sel_init_a, en_sub_a, en_shift_a, en_mix_a, en_ark_a;
  logic       mix_bypass_a, key_req_a;
  logic [3:0] round_idx_a;
  logic [2:0] dbg_state_a;
  logic       busy_b, done_b, sel_init_b, en_sub_b, en_shift_b, en_mix_b, en_ark_b;
  logic       mix_bypass_b, key_req_b;
  logic [3:0] round_idx_b;
  logic [2:0] dbg_state_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut_a (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
    .busy(busy_a), .done(done_a), .round_idx(round_idx_a), .sel_init(sel_init_a),
    .en_sub(en_sub_a), .en_shift(en_shift_a), .en_mix(en_mix_a), .en_ark(en_ark_a),
    .mix_bypass(mix_bypass_a), .key_req(key_req_a), .dbg_state(dbg_state_a)
  );

  aes_round_ctrl #(.NR(14)) dut_b (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
    .busy(busy_b), .done(done_b), .round_idx(round_idx_b), .sel_init(sel_init_b),
    .en_sub(en_sub_b), .en_shift(en_shift_b), .en_mix(en_mix_b), .en_ark(en_ark_b),
    .mix_bypass(mix_bypass_b), .key_req(key_req_b), .dbg_state(dbg_state_b)
  );

  // {round_idx, busy, done, sel_init, key_req, en_sub, en_shift, en_mix, en_ark, mix_bypass}
  logic [12:0] vec_a, vec_b;
  assign vec_a = {round_idx_a, busy_a, done_a, sel_init_a, key_req_a,
                  en_sub_a, en_shift_a, en_mix_a, en_ark_a, mix_bypass_a};
  assign vec_b = {round_idx_b, busy_b, done_b, sel_init_b, key_req_b,
                  en_sub_b, en_shift_b, en_mix_b, en_ark_b, mix_bypass_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(input int r, input bit bsy, input bit dn, input bit si,
                                     input bit kr, input bit sb, input bit sh, input bit mx,
                                     input bit ak, input bit bp);
    return {4'(r), bsy, dn, si, kr, sb, sh, mx, ak, bp};
  endfunction

  // Outputs k cycles after the start edge with the key always ready.
  function automatic logic [12:0] base_vec(input int k, input int nr);
    int r, p;
    if (k < 0 || k > 4 * nr) return 13'd0;
    if (k == 0) return mk(0, 1, 0, 1, 1, 0, 0, 0, 1, 0);
    if (k == 4 * nr) return mk(nr, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    r = (k - 1) / 4 + 1;
    p = (k - 1) % 4;
    if (p == 0) return mk(r, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    if (p == 1) return mk(r, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    if (p == 2 && r == nr) return mk(r, 1, 0, 0, 1, 0, 0, 0, 1, 1);
    if (p == 2) return mk(r, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    return mk(r, 1, 0, 0, 1, 0, 0, 0, 1, 0);
  endfunction

  function automatic logic [12:0] exp_vec(input int k, input int nr, input int st_at,
                                          input int st_len, input bit b2b, input int rst_at);
    int kk;
    kk = k;
    if (rst_at >= 0 && kk > rst_at) return 13'd0;
    if (b2b) kk = kk % (4 * nr + 2);
    if (st_len > 0 && kk >= st_at && kk < st_at + st_len)
      return mk(st_at / 4, 1, 0, 0, 1, 0, 0, 0, 0, (st_at / 4) == nr);
    if (st_len > 0 && kk >= st_at + st_len) kk = kk - st_len;
    return base_vec(kk, nr);
  endfunction

  // Per-cycle structural rules on both instances.
  logic prev_sub_a = 1'b0, prev_sub_b = 1'b0, prev_rst = 1'b1;
  always @(negedge clk) begin
    check("onehot_a", 32'($countones({en_sub_a, en_shift_a, en_mix_a, en_ark_a}) <= 1), 32'd1);
    check("onehot_b", 32'($countones({en_sub_b, en_shift_b, en_mix_b, en_ark_b}) <= 1), 32'd1);
    if (!prev_rst) begin
      check("shift_after_sub_a", 32'(en_shift_a), 32'(prev_sub_a));
      check("shift_after_sub_b", 32'(en_shift_b), 32'(prev_sub_b));
    end
    prev_sub_a = en_sub_a;
    prev_sub_b = en_sub_b;
    prev_rst   = rst;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; key_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Starts one run with start sampled at E0 and checks both instances for n cycles.
  task automatic run(input string name, input int n, input int st_at, input int st_len,
                     input bit b2b, input int rst_at, output int done_k_a,
                     output int done_k_b, output int max_b);
    int k;
    done_k_a = -1;
    done_k_b = -1;
    max_b    = 0;
    start    = 1'b1;
    k        = -1;
    repeat (n) begin
      @(posedge clk); #1;
      k++;
      start     = b2b;
      key_valid = !(st_len > 0 && k >= st_at && k < st_at + st_len);
      rst       = (k == rst_at);
      @(negedge clk);
      check({name, "_a"}, 32'(vec_a), 32'(exp_vec(k, 10, st_at, st_len, b2b, rst_at)));
      check({name, "_b"}, 32'(vec_b), 32'(exp_vec(k, 14, st_at, st_len, b2b, rst_at)));
      if (done_a && done_k_a < 0) done_k_a = k;
      if (done_b && done_k_b < 0) done_k_b = k;
      if (int'(round_idx_b) > max_b) max_b = int'(round_idx_b);
    end
    start = 1'b0;
    rst   = 1'b0;
    key_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int da, db, mb;
    // Reset asserted together with start: reset wins.
    rst = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_vec_a", 32'(vec_a), 32'd0);
    check("reset_vec_b", 32'(vec_b), 32'd0);
    do_reset();
    check("post_reset_a", 32'(vec_a), 32'd0);

    run("nominal", 60, 0, 0, 1'b0, -1, da, db, mb);
    check("done_lat_nr10", 32'(da), 32'd40);
    check("done_lat_nr14", 32'(db), 32'd56);
    check("max_round_nr14", 32'(mb), 32'd14);
    do_reset();

    run("stall", 62, 20, 3, 1'b0, -1, da, db, mb);
    check("stall_done_nr10", 32'(da), 32'd43);
    check("stall_done_nr14", 32'(db), 32'd59);
    do_reset();

    run("b2b", 100, 0, 0, 1'b1, -1, da, db, mb);
    check("b2b_first_done", 32'(da), 32'd40);
    do_reset();

    run("midrst", 32, 0, 0, 1'b0, 27, da, db, mb);
    check("midrst_no_done", 32'(da), 32'hFFFF_FFFF);
    check("midrst_round_idx", 32'(round_idx_a), 32'd0);
    repeat (2) @(negedge clk);

    run("rerun", 60, 0, 0, 1'b0, -1, da, db, mb);
    check("rerun_done_nr10", 32'(da), 32'd40);
    check("rerun_done_nr14", 32'(db), 32'd56);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of cipher rounds; legal values 10, 12, 14.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to encrypt the block currently presented to the datapath.
REQ-005 key_valid  input  1  key schedule has the round key for round_idx ready.
REQ-006 busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-007 done  output  1  one-cycle pulse; datapath output register holds the ciphertext.
REQ-008 round_idx  output  4  current round number: 0 = initial key add, 1..NR = rounds.
REQ-009 sel_init  output  1  datapath input mux selects plaintext (1) or loop-back state (0).
REQ-010 en_sub, en_shift, en_mix, en_ark  output  1 each  load enables for the registered SubBytes, ShiftRows, MixColumns and AddRoundKey stages.
REQ-011 mix_bypass  output  1  routes the ShiftRows output around MixColumns to AddRoundKey.
REQ-012 key_req  output  1  requests the round key for round_idx from the key schedule.

Function
REQ-013 States: IDLE, INIT, SUB, SHIFT, MIX, ARK, DONE; encoding is free.
REQ-014 IDLE: all outputs 0; start=1 -> INIT with round_idx=0. start=0 -> remain in IDLE.
REQ-015 INIT: sel_init=1, key_req=1; en_ark=1 only when key_valid=1.
- key_valid=1 -> SUB with round_idx=1.
- key_valid=0 -> stall in INIT.
REQ-016 SUB: en_sub=1 -> SHIFT.
REQ-017 SHIFT: en_shift=1.
- round_idx<NR -> MIX.
- round_idx=NR -> ARK with mix_bypass=1.
REQ-018 MIX: en_mix=1 -> ARK.
REQ-019 ARK: key_req=1; en_ark=key_valid; mix_bypass=1 iff round_idx=NR.
- key_valid=0 -> stall in ARK; all enables 0 except key_req.
- key_valid=1 and round_idx<NR -> SUB, round_idx+1.
- key_valid=1 and round_idx=NR -> DONE.
REQ-020 DONE: done=1 for exactly one cycle -> IDLE; round_idx is held at NR during DONE and cleared to 0 on entry to IDLE.
REQ-021 At most one of en_sub, en_shift, en_mix, en_ark is high in any cycle.
REQ-022 start is ignored in every state other than IDLE; a start in DONE is not queued.
REQ-023 Latency with key_valid held high: start sampled at edge E0 -> done high in the cycle after edge E(4*NR). For NR=10 that is after E40.
REQ-024 round_idx never exceeds NR and never wraps.

Reset
REQ-025 rst=1 at a clock edge forces IDLE regardless of state, including mid-round or mid-stall.
REQ-026 After reset: round_idx=0 and every output is 0.
REQ-027 rst has priority over start in the same cycle.

Verification
REQ-028 NR=10, key_valid=1, start pulse at E0 -> INIT after E0; SUB/SHIFT/MIX/ARK sequence repeats for rounds 1-9; round 10 is SUB, SHIFT, ARK with mix_bypass=1; done after E40; busy low after E41.
REQ-029 key_valid held 0 for 3 cycles in round-5 ARK -> controller stays in ARK 3 extra cycles with en_ark=0 and key_req=1; done is delayed by exactly 3 cycles.
REQ-030 start held high continuously -> back-to-back encryptions; each done is followed by one IDLE cycle, then INIT.
REQ-031 rst asserted during round-7 MIX -> IDLE next cycle with round_idx=0; a later start runs a full, correct sequence.
REQ-032 NR=14, key_valid=1 -> done after E56; the maximum round_idx observed is 14.
REQ-033 Every cycle of every test -> the enable one-hot-or-zero rule holds, and the ShiftRows enable is always the cycle immediately after the SubBytes enable.
